// File: rtl/tmr_fault_logger_pkg.sv
// Shared constants for the TMR fault logger: register offsets, log entry layout, STATUS bits.
// Timestamping is controlled by the FAULT_LOG_TIMESTAMP_EN macro in the top level.
package tmr_fault_logger_pkg;

    // Register offsets, decoded from wbs_adr_i[3:2]
    localparam logic [1:0] RegStatus = 2'd0;
    localparam logic [1:0] RegPop    = 2'd1;
    localparam logic [1:0] RegClear  = 2'd2;
    localparam logic [1:0] RegTotal  = 2'd3;

    // Log entry layout: [31:8] timestamp, [7:6] zero, [5:0] fault vector
    localparam int unsigned EntryW     = 32;
    localparam int unsigned EntryFvLsb = 0;
    localparam int unsigned EntryFvW   = 6;
    localparam int unsigned EntryTsLsb = 8;
    localparam int unsigned EntryTsW   = 24;

    // STATUS register layout
    localparam int unsigned StatusCountLsb = 0;
    localparam int unsigned StatusCountW   = 8;
    localparam int unsigned StatusEmptyBit = 15;
    localparam int unsigned StatusOvfBit   = 16;

    localparam int unsigned TotalW = 16;

    typedef enum logic {
        BusIdle,
        BusResp
    } bus_state_e;

endpackage

// File: rtl/tmr_fault_logger_fault_fifo.sv
// Synchronous FIFO holding fault log entries; push and pop may occur in the same cycle,
// so a push into a full FIFO is accepted when a pop frees the head slot at the same time.
module tmr_fault_logger_fault_fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clr_i,
    input  logic                   push_i,
    input  logic [Width-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [Width-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(Depth):0] count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [Width-1:0] mem_q [Depth];
    logic             push_en, pop_en;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        pop_en   = pop_i && !empty_o && !clr_i;
        push_en  = push_i && !clr_i && (!full_o || pop_en);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(push_en) - CntW'(pop_en);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through the count
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/tmr_fault_logger.sv
// Logs changes of the TMR voter mismatch flags into a FIFO readable over a simple bus.
// Define FAULT_LOG_TIMESTAMP_EN to add a free-running timestamp to each log entry.
module tmr_fault_logger
    import tmr_fault_logger_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 32,
    parameter logic [19:0] ADDRBASE  = 20'h3002_0,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned TS_WIDTH  = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           output_io_error,
    input  logic [2:0]           trx_error,
    input  logic                 valid_i,
    input  logic                 wbs_we_i,
    input  logic [31:0]          wbs_adr_i,
    input  logic [WORD_SIZE-1:0] wdata_i,
    input  logic [3:0]           wstrb_i,
    output logic                 ready_o,
    output logic [WORD_SIZE-1:0] rdata_o,
    output logic                 fault_irq
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    // Reset asserts asynchronously and releases two clock edges later
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n_int;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_n_int  = rst_sync_q[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    logic [5:0]        fv;
    logic [5:0]        fv_q, fv_d;
    logic              fault_event;
    logic              overflow_q, overflow_d;
    logic [TotalW-1:0] total_q, total_d;
    logic [EntryTsW-1:0] entry_ts;
    logic [EntryW-1:0] entry;

    assign fv          = {trx_error, output_io_error};
    assign fault_event = (fv != fv_q) && (fv != '0);

`ifdef FAULT_LOG_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_q, ts_d;

    assign ts_d     = ts_q + TS_WIDTH'(1);
    assign entry_ts = EntryTsW'(ts_q);

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end
`else
    logic [TS_WIDTH-1:0] unused_ts;

    assign unused_ts = '0;
    assign entry_ts  = '0;
`endif

    always_comb begin
        entry = '0;
        entry[EntryTsLsb +: EntryTsW] = entry_ts;
        entry[EntryFvLsb +: EntryFvW] = fv;
    end

    bus_state_e      state_q, state_d;
    logic            ready_q, ready_d;
    logic [EntryW-1:0] rdata_q, rdata_d;
    logic [1:0]      reg_off;
    logic            accept, clear_req, pop_req;
    logic [EntryW-1:0] rd_word;

    logic [EntryW-1:0] fifo_rdata;
    logic              fifo_full, fifo_empty;
    logic [CntW-1:0]   fifo_count;

    assign reg_off   = wbs_adr_i[3:2];
    assign accept    = valid_i && (wbs_adr_i[31:12] == ADDRBASE) && (state_q == BusIdle);
    assign clear_req = accept && wbs_we_i && (wstrb_i != 4'h0) && (reg_off == RegClear);
    assign pop_req   = accept && !wbs_we_i && (reg_off == RegPop);

    tmr_fault_logger_fault_fifo #(
        .Width(EntryW),
        .Depth(DEPTH)
    ) u_fault_fifo (
        .clk_i  (clk),
        .rst_ni (rst_n_int),
        .clr_i  (clear_req),
        .push_i (fault_event && !clear_req),
        .wdata_i(entry),
        .pop_i  (pop_req),
        .rdata_o(fifo_rdata),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .count_o(fifo_count)
    );

    always_comb begin
        rd_word = '0;
        case (reg_off)
            RegStatus: begin
                rd_word[StatusOvfBit]   = overflow_q;
                rd_word[StatusEmptyBit] = fifo_empty;
                rd_word[StatusCountLsb +: StatusCountW] = StatusCountW'(fifo_count);
            end
            RegPop:   rd_word = fifo_empty ? '0 : fifo_rdata;
            RegTotal: rd_word = {{(EntryW - TotalW){1'b0}}, total_q};
            default:  rd_word = '0;
        endcase
    end

    // A full FIFO only overflows when no pop frees a slot in the same cycle
    always_comb begin
        fv_d       = fv;
        overflow_d = overflow_q;
        total_d    = total_q;
        if (clear_req) begin
            overflow_d = 1'b0;
            total_d    = '0;
        end else if (fault_event) begin
            if (total_q != '1) begin
                total_d = total_q + TotalW'(1);
            end
            if (fifo_full && !pop_req) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            fv_q       <= '0;
            overflow_q <= 1'b0;
            total_q    <= '0;
        end else begin
            fv_q       <= fv_d;
            overflow_q <= overflow_d;
            total_q    <= total_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        rdata_d = '0;
        case (state_q)
            BusIdle: begin
                if (accept) begin
                    state_d = BusResp;
                    ready_d = 1'b1;
                    rdata_d = wbs_we_i ? '0 : rd_word;
                end
            end
            BusResp: state_d = BusIdle;
            default: state_d = BusIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q <= BusIdle;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

    assign ready_o   = ready_q;
    assign rdata_o   = WORD_SIZE'(rdata_q);
    assign fault_irq = !fifo_empty || overflow_q;

    logic unused_bits;
    assign unused_bits = ^{wdata_i, wbs_adr_i[11:4], wbs_adr_i[1:0]};

endmodule

// File: tb/tb_tmr_fault_logger.sv
// Self-checking bench for tmr_fault_logger: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_tmr_fault_logger;

    localparam logic [19:0] Base  = 20'h30020;
    localparam int          Depth = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  output_io_error, trx_error;
    logic        valid_i, wbs_we_i;
    logic [31:0] wbs_adr_i, wdata_i;
    logic [3:0]  wstrb_i;
    logic        ready_o;
    logic [31:0] rdata_o;
    logic        fault_irq;

    always #5 clk = ~clk;

    tmr_fault_logger #(
        .WORD_SIZE(32),
        .ADDRBASE (Base),
        .DEPTH    (Depth),
        .TS_WIDTH (24)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .output_io_error(output_io_error),
        .trx_error      (trx_error),
        .valid_i        (valid_i),
        .wbs_we_i       (wbs_we_i),
        .wbs_adr_i      (wbs_adr_i),
        .wdata_i        (wdata_i),
        .wstrb_i        (wstrb_i),
        .ready_o        (ready_o),
        .rdata_o        (rdata_o),
        .fault_irq      (fault_irq)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] m_fifo[$];
    logic        m_ovf;
    logic [15:0] m_total;
    logic [5:0]  m_fvq;
    logic [23:0] m_ts;
    logic        m_ready;
    logic [31:0] m_rdata;
    logic        last_ready;
    logic [31:0] last_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = '0;
        s[16] = m_ovf;
        s[15] = (m_fifo.size() == 0);
        s[7:0] = 8'(m_fifo.size());
        return s;
    endfunction

    task automatic model_clear();
        m_fifo.delete();
        m_ovf   = 1'b0;
        m_total = '0;
        m_fvq   = '0;
        m_ts    = '0;
        m_ready = 1'b0;
        m_rdata = '0;
    endtask

    // One clock: drive inputs, advance the model, then compare all outputs at the falling edge
    task automatic cyc(input logic [5:0] fv, input logic v, input logic w,
                       input logic [31:0] a, input logic [3:0] s);
        logic        acc, ev, exp_irq;
        logic [31:0] nrd, entry;
        {trx_error, output_io_error} = fv;
        valid_i   = v;
        wbs_we_i  = w;
        wbs_adr_i = a;
        wstrb_i   = s;
        wdata_i   = $urandom;
        acc = v && (a[31:12] == Base) && !m_ready;
        ev  = (fv != m_fvq) && (fv != 6'd0);
        nrd = '0;
        if (acc && !w) begin
            case (a[3:2])
                2'd0: nrd = m_status();
                2'd1: if (m_fifo.size() != 0) nrd = m_fifo[0];
                2'd3: nrd = {16'h0, m_total};
                default: nrd = '0;
            endcase
        end
`ifdef FAULT_LOG_TIMESTAMP_EN
        entry = {m_ts, 2'b00, fv};
`else
        entry = {24'h0, 2'b00, fv};
`endif
        if (acc && w && (s != 4'h0) && (a[3:2] == 2'd2)) begin
            m_fifo.delete();
            m_ovf   = 1'b0;
            m_total = '0;
        end else begin
            if (acc && !w && (a[3:2] == 2'd1) && (m_fifo.size() != 0)) void'(m_fifo.pop_front());
            if (ev) begin
                if (m_total != 16'hFFFF) m_total = m_total + 16'd1;
                if (m_fifo.size() < Depth) m_fifo.push_back(entry);
                else m_ovf = 1'b1;
            end
        end
        m_ready = acc;
        m_rdata = nrd;
        m_fvq   = fv;
        m_ts    = m_ts + 24'd1;
        @(posedge clk);
        @(negedge clk);
        last_ready = ready_o;
        last_rdata = rdata_o;
        exp_irq = (m_fifo.size() != 0) || m_ovf;
        check("ready_o", {31'b0, ready_o}, {31'b0, m_ready});
        check("rdata_o", rdata_o, m_rdata);
        check("fault_irq", {31'b0, fault_irq}, {31'b0, exp_irq});
    endtask

    // Single bus transaction followed by one idle cycle; returns the response data
    task automatic bus(input logic w, input logic [1:0] off, input logic [5:0] fv,
                       output logic [31:0] rd);
        cyc(fv, 1'b1, w, {Base, 8'h00, off, 2'b00}, 4'hF);
        rd = last_rdata;
        check("ack_pulse", {31'b0, last_ready}, 32'd1);
        cyc(fv, 1'b0, 1'b0, 32'h0, 4'h0);
        check("ack_drop", {31'b0, last_ready}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        {trx_error, output_io_error} = 6'd0;
        valid_i = 1'b0; wbs_we_i = 1'b0; wbs_adr_i = '0; wdata_i = '0; wstrb_i = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", {31'b0, ready_o}, 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_irq", {31'b0, fault_irq}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        model_clear();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] exp_pop;
        logic [5:0]  fv;
        logic [31:0] a;
        logic        v, w;
        logic [3:0]  s;

        do_reset();

        // First event after 10 idle cycles carries timestamp 10
        for (int i = 0; i < 10; i++) cyc(6'd0, 1'b0, 1'b0, 32'h0, 4'h0);
        cyc(6'h01, 1'b0, 1'b0, 32'h0, 4'h0);
        bus(1'b0, 2'd0, 6'h01, rd);
        check("status_one", rd, 32'h0000_0001);
`ifdef FAULT_LOG_TIMESTAMP_EN
        exp_pop = 32'h0000_0A01;
`else
        exp_pop = 32'h0000_0001;
`endif
        bus(1'b0, 2'd1, 6'h01, rd);
        check("pop_first", rd, exp_pop);
        check("irq_after_pop", {31'b0, fault_irq}, 32'd0);

        // Held fault vector logs once
        bus(1'b1, 2'd2, 6'h01, rd);
        for (int i = 0; i < 20; i++) cyc(6'h08, 1'b0, 1'b0, 32'h0, 4'h0);
        bus(1'b0, 2'd0, 6'h08, rd);
        check("held_status", rd, 32'h0000_0001);
        bus(1'b0, 2'd3, 6'h08, rd);
        check("held_total", rd, 32'h0000_0001);

        // Ten distinct events overflow an eight-entry FIFO
        bus(1'b1, 2'd2, 6'h08, rd);
        for (int i = 1; i <= 10; i++) cyc(6'(i), 1'b0, 1'b0, 32'h0, 4'h0);
        bus(1'b0, 2'd0, 6'd10, rd);
        check("ovf_status", rd, 32'h0001_0008);
        bus(1'b0, 2'd3, 6'd10, rd);
        check("ovf_total", rd, 32'h0000_000A);
        check("ovf_irq", {31'b0, fault_irq}, 32'd1);
        bus(1'b1, 2'd2, 6'd10, rd);
        bus(1'b0, 2'd0, 6'd10, rd);
        check("clear_status", rd, 32'h0000_8000);
        check("clear_irq", {31'b0, fault_irq}, 32'd0);

        // Full FIFO: event coinciding with POP pushes and pops, no overflow
        for (int i = 1; i <= 8; i++) cyc(6'(i), 1'b0, 1'b0, 32'h0, 4'h0);
        bus(1'b0, 2'd1, 6'd9, rd);
        check("full_pop_fv", {24'h0, rd[7:0]}, 32'h0000_0001);
        bus(1'b0, 2'd0, 6'd9, rd);
        check("full_pop_status", rd, 32'h0000_0008);

        // POP on empty, then a non-matching base address
        bus(1'b1, 2'd2, 6'd9, rd);
        bus(1'b0, 2'd1, 6'd9, rd);
        check("pop_empty", rd, 32'h0000_0000);
        for (int i = 0; i < 3; i++) begin
            cyc(6'd9, 1'b1, 1'b0, 32'h3003_0000, 4'h0);
            check("bad_base", {31'b0, last_ready}, 32'd0);
        end

        // Reset asserted while the response is being presented
        cyc(6'd1, 1'b0, 1'b0, 32'h0, 4'h0);
        cyc(6'd2, 1'b0, 1'b0, 32'h0, 4'h0);
        cyc(6'd2, 1'b1, 1'b0, {Base, 12'h000}, 4'h0);
        check("pre_rst_ack", {31'b0, last_ready}, 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_ready", {31'b0, ready_o}, 32'd0);
        check("mid_rst_rdata", rdata_o, 32'd0);
        do_reset();
        bus(1'b0, 2'd0, 6'd0, rd);
        check("post_rst_status", rd, 32'h0000_8000);
        bus(1'b0, 2'd3, 6'd0, rd);
        check("post_rst_total", rd, 32'h0000_0000);

        // Randomized traffic against the model
        fv = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 3) fv = 6'($urandom);
            v = ($urandom_range(0, 9) < 4);
            w = ($urandom_range(0, 3) == 0);
            a = {Base, 8'($urandom), 2'($urandom), 2'($urandom)};
            if ($urandom_range(0, 15) == 0) a[31:12] = 20'h30030;
            s = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            cyc(fv, v, w, a, s);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
